// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NRD_DEF   = 4;
  localparam int unsigned NWR_DEF   = 2;

  // Register address width for a register count; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned nregs);
    return (nregs <= 1) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one bit per register, set by issue, cleared by committed
// writes, with set taking priority. Also provides the per-read-port busy view.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = NRD_DEF,
  parameter int unsigned NWR    = NWR_DEF,
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned AW     = addr_w(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NWR-1:0]    iss_en,
  input  logic [NWR*AW-1:0] iss_addr,
  input  logic [NWR-1:0]    clr_en,
  input  logic [NWR*AW-1:0] clr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  // Decode set/clear requests and apply them with set-over-clear priority; r0 never busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int j = 0; j < int'(NWR); j++) begin
      if (iss_en[j]) set_vec[iss_addr[j*AW +: AW]] = 1'b1;
      if (clr_en[j]) clr_vec[clr_addr[j*AW +: AW]] = 1'b1;
    end
    set_vec[0] = 1'b0;
    busy_d     = set_vec | (busy_q & ~clr_vec);
    busy_d[0]  = 1'b0;
  end

  // Busy bit storage.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Busy read-out: with bypass, a same-cycle clear hides the bit unless a new set lands too.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      if (BYPASS)
        rd_busy[i] = busy_q[rd_addr[i*AW +: AW]] &
                     (set_vec[rd_addr[i*AW +: AW]] | ~clr_vec[rd_addr[i*AW +: AW]]);
      else
        rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
      if (reset) rd_busy[i] = 1'b0;
    end
  end

endmodule

// File: rtl/mp_regfile_sb.sv
// Multi-port register file with write->read bypass, busy scoreboard and
// registered write-echo outputs for the forwarding network.
// Handshake: no backpressure; wr_en/iss_en are accepted in the cycle they are
// high, and wb_valid is a one-cycle pulse one cycle after each committed write.
module mp_regfile_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = NRD_DEF,
  parameter int unsigned NWR    = NWR_DEF,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      iss_en,
  input  logic [NWR*AW-1:0]   iss_addr,
  output logic [NWR-1:0]      wb_valid,
  output logic [NWR*AW-1:0]   wb_addr,
  output logic [NWR*XLEN-1:0] wb_data
);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic [NWR-1:0]      win;
  logic [NWR-1:0]      wb_valid_q, wb_valid_d;
  logic [NWR*AW-1:0]   wb_addr_q,  wb_addr_d;
  logic [NWR*XLEN-1:0] wb_data_q,  wb_data_d;
  logic [AW-1:0]       rd_a;
  logic [XLEN-1:0]     rd_v;

  // A write port commits only if it targets a non-zero register and no higher port hits the same one.
  for (genvar j = 0; j < int'(NWR); j++) begin : g_win
    logic beaten;
    // Look for a higher-indexed enabled port with the same address.
    always_comb begin
      beaten = 1'b0;
      for (int k = j + 1; k < int'(NWR); k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] == wr_addr[j*AW +: AW])) beaten = 1'b1;
      end
    end
    assign win[j] = wr_en[j] && (wr_addr[j*AW +: AW] != '0) && !beaten;
  end

  // Next array contents: winners are unique per address, so order does not matter.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < int'(NWR); j++) begin
      if (win[j]) regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    end
    regs_d[0] = '0;
  end

  // Register array storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: array value, optionally overridden by a same-cycle winning write.
  always_comb begin
    rs_data = '0;
    rd_a    = '0;
    rd_v    = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      rd_a = rs_addr[i*AW +: AW];
      rd_v = regs_q[rd_a];
      if (BYPASS) begin
        for (int j = 0; j < int'(NWR); j++) begin
          if (win[j] && (wr_addr[j*AW +: AW] == rd_a)) rd_v = wr_data[j*XLEN +: XLEN];
        end
      end
      if (reset || (rd_a == '0)) rd_v = '0;
      rs_data[i*XLEN +: XLEN] = rd_v;
    end
  end

  // Echo of this cycle's committed writes; address/data are zero on idle ports.
  always_comb begin
    wb_valid_d = win;
    wb_addr_d  = '0;
    wb_data_d  = '0;
    for (int j = 0; j < int'(NWR); j++) begin
      if (win[j]) begin
        wb_addr_d[j*AW +: AW]     = wr_addr[j*AW +: AW];
        wb_data_d[j*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Write-echo registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .clr_en   (win),
    .clr_addr (wr_addr),
    .rd_addr  (rs_addr),
    .rd_busy  (rs_busy)
  );

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Bench for mp_regfile_sb: BYPASS=1 and BYPASS=0 instances share stimulus and
// are checked against an array-based reference model through an expected queue.
module tb_mp_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  typedef struct packed {
    logic                wb_chk;
    logic [NWR-1:0]      wbv;
    logic [NWR*AW-1:0]   wba;
    logic [NWR*XLEN-1:0] wbd;
    logic [NRD*XLEN-1:0] rd1;
    logic [NRD-1:0]      bz1;
    logic [NRD*XLEN-1:0] rd0;
    logic [NRD-1:0]      bz0;
  } exp_t;
  localparam int EW = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset = 1'b1;
  logic [NRD*AW-1:0]   rs_addr = '0;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic [NWR-1:0]      iss_en = '0;
  logic [NWR*AW-1:0]   iss_addr = '0;

  logic [NRD*XLEN-1:0] rs_data_b1, rs_data_b0;
  logic [NRD-1:0]      rs_busy_b1, rs_busy_b0;
  logic [NWR-1:0]      wb_valid_b1, wb_valid_b0;
  logic [NWR*AW-1:0]   wb_addr_b1, wb_addr_b0;
  logic [NWR*XLEN-1:0] wb_data_b1, wb_data_b0;

  mp_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)) dut_b1 (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data_b1), .rs_busy(rs_busy_b1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .wb_valid(wb_valid_b1), .wb_addr(wb_addr_b1), .wb_data(wb_data_b1)
  );

  mp_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0)) dut_b0 (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data_b0), .rs_busy(rs_busy_b0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .wb_valid(wb_valid_b0), .wb_addr(wb_addr_b0), .wb_data(wb_data_b0)
  );

  // ---------------- reference model state ----------------
  logic [XLEN-1:0]     m_regs [NREGS];
  bit                  m_busy [NREGS];
  logic [NWR-1:0]      m_wbv = '0;
  logic [NWR*AW-1:0]   m_wba = '0;
  logic [NWR*XLEN-1:0] m_wbd = '0;
  bit                  m_known = 1'b0;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver ----------------
  // Applies one cycle of inputs at the falling edge, queues the expected
  // outputs for that cycle, then advances the model past the next rising edge.
  task automatic step(input bit rst,
                      input logic [NWR-1:0] we, input logic [NWR*AW-1:0] wa,
                      input logic [NWR*XLEN-1:0] wd,
                      input logic [NWR-1:0] ie, input logic [NWR*AW-1:0] ia,
                      input logic [NRD*AW-1:0] ra);
    logic [XLEN-1:0]     nregs [NREGS];
    bit                  written [NREGS];
    bit                  issued [NREGS];
    int                  last [NREGS];
    logic [NWR-1:0]      nwbv;
    logic [NWR*AW-1:0]   nwba;
    logic [NWR*XLEN-1:0] nwbd;
    logic [AW-1:0]       a;
    exp_t                e;
    @(negedge clk);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; rs_addr = ra;

    for (int r = 0; r < NREGS; r++) begin
      nregs[r] = m_regs[r]; written[r] = 1'b0; issued[r] = 1'b0; last[r] = -1;
    end
    // Apply writes in ascending port order so the highest port naturally wins.
    for (int j = 0; j < NWR; j++) begin
      a = wa[j*AW +: AW];
      if (we[j] && a != 0) begin
        nregs[a] = wd[j*XLEN +: XLEN]; written[a] = 1'b1; last[a] = j;
      end
    end
    nwbv = '0; nwba = '0; nwbd = '0;
    for (int j = 0; j < NWR; j++) begin
      a = wa[j*AW +: AW];
      if (we[j] && a != 0 && last[a] == j) begin
        nwbv[j] = 1'b1; nwba[j*AW +: AW] = a; nwbd[j*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
      end
      if (ie[j] && ia[j*AW +: AW] != 0) issued[ia[j*AW +: AW]] = 1'b1;
    end

    e = '0;
    e.wb_chk = m_known; e.wbv = m_wbv; e.wba = m_wba; e.wbd = m_wbd;
    for (int i = 0; i < NRD; i++) begin
      a = ra[i*AW +: AW];
      if (!rst) begin
        e.rd1[i*XLEN +: XLEN] = nregs[a];
        e.rd0[i*XLEN +: XLEN] = m_regs[a];
        e.bz0[i] = m_busy[a];
        // Bypassed busy is "busy now and still busy after this cycle".
        e.bz1[i] = m_busy[a] && (issued[a] || !written[a]);
      end
    end
    exp_q.push_back(EW'(e));

    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
      m_wbv = '0; m_wba = '0; m_wbd = '0; m_known = 1'b1;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = nregs[r];
        m_busy[r] = (r != 0) && (issued[r] || (m_busy[r] && !written[r]));
      end
      m_wbv = nwbv; m_wba = nwba; m_wbd = nwbd;
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS - 1)) : AW'($urandom_range(0, 7));
  endfunction

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string nm, input int p, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, p, $time, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        for (int i = 0; i < NRD; i++) begin
          chk("rs_data_b1", i, rs_data_b1[i*XLEN +: XLEN], e.rd1[i*XLEN +: XLEN]);
          chk("rs_busy_b1", i, XLEN'(rs_busy_b1[i]), XLEN'(e.bz1[i]));
          chk("rs_data_b0", i, rs_data_b0[i*XLEN +: XLEN], e.rd0[i*XLEN +: XLEN]);
          chk("rs_busy_b0", i, XLEN'(rs_busy_b0[i]), XLEN'(e.bz0[i]));
        end
        if (e.wb_chk) begin
          for (int j = 0; j < NWR; j++) begin
            chk("wb_valid_b1", j, XLEN'(wb_valid_b1[j]), XLEN'(e.wbv[j]));
            chk("wb_valid_b0", j, XLEN'(wb_valid_b0[j]), XLEN'(e.wbv[j]));
            if (e.wbv[j]) begin
              chk("wb_addr_b1", j, XLEN'(wb_addr_b1[j*AW +: AW]), XLEN'(e.wba[j*AW +: AW]));
              chk("wb_data_b1", j, wb_data_b1[j*XLEN +: XLEN], e.wbd[j*XLEN +: XLEN]);
              chk("wb_addr_b0", j, XLEN'(wb_addr_b0[j*AW +: AW]), XLEN'(e.wba[j*AW +: AW]));
              chk("wb_data_b0", j, wb_data_b0[j*XLEN +: XLEN], e.wbd[j*XLEN +: XLEN]);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NWR-1:0]      we, ie;
    logic [NWR*AW-1:0]   wa, ia;
    logic [NWR*XLEN-1:0] wd;
    logic [NRD*AW-1:0]   ra;

    for (int r = 0; r < NREGS; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end

    // Power-on reset.
    step(1, '0, '0, '0, '0, '0, '0);
    step(1, '0, '0, '0, '0, '0, '0);

    // Reset: r5 written, then a reset cycle (with writes/iss that must be dropped) clears it.
    step(0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEAD}, '0, '0, {5'd5, 5'd5, 5'd5, 5'd5});
    step(0, '0, '0, '0, 2'b01, {5'd0, 5'd6}, {5'd5, 5'd6, 5'd5, 5'd5});
    step(1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hBEEF}, 2'b01, {5'd0, 5'd5}, {5'd5, 5'd6, 5'd5, 5'd5});
    step(0, '0, '0, '0, '0, '0, {5'd5, 5'd6, 5'd5, 5'd5});

    // Collision on r7: port 1 wins, echo shows only port 1.
    step(0, 2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, '0, '0, {5'd7, 5'd7, 5'd7, 5'd7});
    step(0, '0, '0, '0, '0, '0, {5'd7, 5'd7, 5'd7, 5'd7});

    // Bypass: rs_addr[2] reads r3 while it is written.
    step(0, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hABCD}, '0, '0, {5'd0, 5'd3, 5'd0, 5'd0});
    step(0, '0, '0, '0, '0, '0, {5'd0, 5'd3, 5'd0, 5'd0});

    // Scoreboard: issue r9, observe busy, write r9 clears it.
    step(0, '0, '0, '0, 2'b01, {5'd0, 5'd9}, {5'd9, 5'd9, 5'd9, 5'd9});
    step(0, '0, '0, '0, '0, '0, {5'd9, 5'd9, 5'd9, 5'd9});
    step(0, 2'b10, {5'd9, 5'd0}, {32'h99, 32'h0}, '0, '0, {5'd9, 5'd9, 5'd9, 5'd9});
    step(0, '0, '0, '0, '0, '0, {5'd9, 5'd9, 5'd9, 5'd9});

    // Set/clear race on r9: the set wins.
    step(0, '0, '0, '0, 2'b10, {5'd9, 5'd0}, {5'd9, 5'd9, 5'd9, 5'd9});
    step(0, 2'b01, {5'd0, 5'd9}, {32'h0, 32'h1234}, 2'b01, {5'd0, 5'd9}, {5'd9, 5'd9, 5'd9, 5'd9});
    step(0, '0, '0, '0, '0, '0, {5'd9, 5'd9, 5'd9, 5'd9});

    // r0: write and issue are ignored.
    step(0, 2'b11, {5'd0, 5'd0}, {32'hFFFF, 32'hFFFF}, 2'b11, {5'd0, 5'd0}, {5'd0, 5'd0, 5'd0, 5'd0});
    step(0, '0, '0, '0, '0, '0, {5'd0, 5'd0, 5'd0, 5'd9});

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      we = NWR'($urandom_range(0, (1 << NWR) - 1));
      ie = NWR'($urandom_range(0, (1 << NWR) - 1));
      for (int j = 0; j < NWR; j++) begin
        wa[j*AW +: AW]     = rnd_addr();
        ia[j*AW +: AW]     = rnd_addr();
        wd[j*XLEN +: XLEN] = $urandom();
      end
      for (int i = 0; i < NRD; i++) ra[i*AW +: AW] = rnd_addr();
      step(($urandom_range(0, 59) == 0), we, wa, wd, ie, ia, ra);
    end

    // Drain the expected queue within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #3;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
